// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the data load/store port.
// Takes one request at a time, holds it for LATENCY wait states, performs a
// byte-enabled word access into an internal array and returns the result on a
// valid/ready response channel.
// Optional build macro DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_reg;
    logic [3:0]    cnt_reg;
    logic          we_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          rd_ok_reg;
    logic          err_reg;
    logic [31:0]   rd_word;
    logic [AW-1:0] word_idx;
    logic          addr_ok;
    logic          access;
    logic          wr_en;

    assign word_idx  = addr_reg[AW+1:2];
    assign addr_ok   = (addr_reg[1:0] == 2'b00) && (addr_reg[31:AW+2] == '0);
    // The access edge is the last WAIT edge; a reset on that edge suppresses it.
    assign access    = srst && (state_reg == WAIT) && (cnt_reg == 4'd0);
    assign wr_en     = access && we_reg && addr_ok;

    assign req_ready = srst && (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    // Read data is only exposed for an error-free load; everything else reads 0.
    assign rsp_rdata = rd_ok_reg ? rd_word : 32'd0;
    assign rsp_err   = err_reg;

    // Control FSM: accept, count down wait states, hold response until taken.
    // LATENCY=0 still passes through WAIT with a zero count, which is exactly
    // the single access edge following acceptance.
    always_ff @(posedge clk) begin
        if (!srst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rd_ok_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        cnt_reg   <= 4'(LATENCY);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                        err_reg   <= !addr_ok;
                        rd_ok_reg <= !we_reg && addr_ok;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                        err_reg   <= 1'b0;
                        rd_ok_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Request capture; pure datapath, so no reset is needed.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
        end
    end

    // One byte-wide array per lane keeps byte enables as plain write enables.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            // Lane write plus registered read, both on the access edge only.
            always_ff @(posedge clk) begin
                if (wr_en && be_reg[gi]) begin
                    mem[word_idx] <= wdata_reg[8*gi +: 8];
                end
                if (access) begin
                    rd_byte_reg <= mem[word_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

`ifdef DMEM_STATS_EN
    // Saturating event counters, bumped on the access edge.
    always_ff @(posedge clk) begin
        if (!srst) begin
            stat_rd  <= 16'd0;
            stat_wr  <= 16'd0;
            stat_err <= 16'd0;
        end else if (access) begin
            if (!addr_ok) begin
                if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
            end else if (we_reg) begin
                if (stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
            end else begin
                if (stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory load/store interface.
- Accepts one request at a time on a valid/ready request channel and holds it for a programmable number of wait states.
- Performs a byte-enabled word read or write into an internal array.
- Returns the result on a valid/ready response channel. It sits between the load/store path of the core and the backing data store, and replaces the zero-latency data memory when wait states must be exercised.

Parameters:
- DEPTH, 256, number of 32-bit words in the array (power of two, 4..4096).
- LATENCY, 2, wait-state cycles between request acceptance and the array access (0..15).

Ports:
- clk  input  1  clock, all logic on the rising edge.
- srst  input  1  synchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables; bit i selects bits [8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  access error (misaligned or out of range).

Behaviour:
- Reset (srst=0 at an edge):
  - state=IDLE, req_ready=0 during the reset cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not reset.
  - Reset mid-transaction abandons the transaction; no write is committed unless the commit edge has already passed.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch we/addr/wdata/be and load the counter with LATENCY.
  - Go to WAIT if LATENCY>0, else go straight to the access step.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When the counter is 0, do the access on that edge and go to RESP.
- Access:
  - word index = addr[log2(DEPTH)+1:2].
  - Misaligned (addr[1:0]!=0) or out of range (addr[31:log2(DEPTH)+2]!=0): rsp_err=1, rsp_rdata=0, array untouched.
  - Store: write only the enabled bytes; rsp_rdata=0. be=0000 is a legal no-op write with rsp_err=0.
  - Load: rsp_rdata = full 32-bit word; req_be is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - The handshake completes on rsp_valid&&rsp_ready; the next state is IDLE with rsp_valid=0, and rsp_rdata/rsp_err cleared to 0.
  - req_ready stays 0 throughout RESP, so there is no new acceptance in the same cycle as response completion.
- Latency: request accepted at edge T; rsp_valid first high in the cycle after edge T+1+LATENCY. With rsp_ready held at 1, throughput is one transaction per LATENCY+3 cycles.
- Only one transaction is ever outstanding.
- Request inputs are don't-care outside the acceptance cycle.
- Read-after-write to the same word returns the newly written bytes, because the accesses are serialized.

Optional Feature:
- Macro DMEM_STATS_EN adds three outputs: stat_rd 16, stat_wr 16, stat_err 16.
- Counters reset to 0 and saturate at 0xFFFF.
- stat_rd / stat_wr increment on the access edge of each error-free load / store.
- stat_err increments on the access edge of each errored transaction.
- Without the macro these ports and counters do not exist; core behaviour is identical either way.

Test Plan:
- LATENCY=2. Store addr=0x10, wdata=0xDEADBEEF, be=1111, then load addr=0x10. Required: load returns rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid first high exactly 3 cycles after acceptance.
- Partial write over the word holding 0xDEADBEEF: store addr=0x10, wdata=0x11223344, be=0101, then load addr=0x10. Required: rsp_rdata=0xDE22BE44.
- Load addr=0x13, then store addr=DEPTH*4 (0x400 for DEPTH=256), then load addr=0x10. Required: the first two responses have rsp_err=1 and rsp_rdata=0; the final load still returns the unchanged word, proving the array was not modified.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid stays 1, data and err are stable, req_ready=0, and a new req_valid is not accepted until 1 cycle after the response handshake.
- Reset mid-WAIT: after a store to 0x20 is accepted, assert srst=0 while the counter is still nonzero. Required: outputs go to their reset values next cycle, and a later load of 0x20 returns the prior contents, not the abandoned store data.
- LATENCY=0 build: back-to-back loads with rsp_ready=1. Required: rsp_valid high 1 cycle after each acceptance; one transaction per 3 cycles.
- With DMEM_STATS_EN: after running the above sequence, the stat_rd/stat_wr/stat_err values match the counts of error-free loads, error-free stores and errored transactions.
